// File: rtl/gfx_pkg.sv
// Shared constants, command field layout and FSM encoding for the rectangle fill engine.
// Coordinates are 13.3 fixed point on the command interface and plain integers internally.
package gfx_pkg;

    localparam int unsigned H_RES     = 640;
    localparam int unsigned V_RES     = 480;
    localparam int unsigned FRAC_BITS = 3;
    localparam int unsigned COLOR_W   = 4;

    // 14 bits holds the sum of two 13-bit integer parts without wrapping
    localparam int unsigned COORD_W = 14;
    localparam int unsigned FIELD_W = 16;
    localparam int unsigned CHAN_W  = 8;
    localparam int unsigned CMD_W   = 88;

    localparam int unsigned X_LSB   = 72;
    localparam int unsigned Y_LSB   = 56;
    localparam int unsigned WID_LSB = 40;
    localparam int unsigned HGT_LSB = 24;
    localparam int unsigned R_LSB   = 16;
    localparam int unsigned G_LSB   = 8;
    localparam int unsigned B_LSB   = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic [FIELD_W-1:0] x;
        logic [FIELD_W-1:0] y;
        logic [FIELD_W-1:0] wid;
        logic [FIELD_W-1:0] hgt;
    } rect_cmd_t;

    // Keeps the low nibble of each 8-bit channel.
    function automatic logic [3*COLOR_W-1:0] pack_color(input logic [CHAN_W-1:0] r,
                                                        input logic [CHAN_W-1:0] g,
                                                        input logic [CHAN_W-1:0] b);
        return {COLOR_W'(r), COLOR_W'(g), COLOR_W'(b)};
    endfunction

endpackage

// File: rtl/fill_rect_clip.sv
// Combinational clipping of a captured fill command against the frame.
// Produces integer start corner, exclusive end corner and an empty flag.
module fill_rect_clip #(
    parameter int unsigned H_RES = gfx_pkg::H_RES,
    parameter int unsigned V_RES = gfx_pkg::V_RES
) (
    input  gfx_pkg::rect_cmd_t            cmd_i,
    output logic [gfx_pkg::COORD_W-1:0]   x0_o,
    output logic [gfx_pkg::COORD_W-1:0]   y0_o,
    output logic [gfx_pkg::COORD_W-1:0]   x_end_o,
    output logic [gfx_pkg::COORD_W-1:0]   y_end_o,
    output logic                          empty_o
);
    import gfx_pkg::*;

    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] x_sum;
    logic [COORD_W-1:0] y_sum;

    always_comb begin
        x0_o = COORD_W'(cmd_i.x >> FRAC_BITS);
        y0_o = COORD_W'(cmd_i.y >> FRAC_BITS);
        w    = COORD_W'(cmd_i.wid >> FRAC_BITS);
        h    = COORD_W'(cmd_i.hgt >> FRAC_BITS);

        x_sum = x0_o + w;
        y_sum = y0_o + h;

        x_end_o = (x_sum > COORD_W'(H_RES)) ? COORD_W'(H_RES) : x_sum;
        y_end_o = (y_sum > COORD_W'(V_RES)) ? COORD_W'(V_RES) : y_sum;

        empty_o = (w == '0) || (h == '0) ||
                  (x0_o >= COORD_W'(H_RES)) || (y0_o >= COORD_W'(V_RES));
    end

endmodule

// File: rtl/fill_rect_engine.sv
// Solid rectangle fill engine: pops one command, clips it and streams one pixel
// write per accepted cycle in raster order, then pulses done.
module fill_rect_engine #(
    parameter int unsigned H_RES  = gfx_pkg::H_RES,
    parameter int unsigned V_RES  = gfx_pkg::V_RES,
    parameter int unsigned ADDR_W = 19
) (
    input  logic                            clk,
    input  logic                            rst_,
    input  logic                            cmd_valid,
    input  logic [gfx_pkg::CMD_W-1:0]       cmd_data,
    output logic                            cmd_rd,
    output logic                            pix_we,
    output logic [ADDR_W-1:0]               pix_addr,
    output logic [3*gfx_pkg::COLOR_W-1:0]   pix_data,
    input  logic                            pix_ready,
    output logic                            busy,
    output logic                            done
);
    import gfx_pkg::*;

    localparam int unsigned PIX_W = 3 * COLOR_W;

    logic [1:0]         state_q, state_d;
    rect_cmd_t          cmd_q, cmd_d;
    logic [PIX_W-1:0]   color_q, color_d;
    logic               cmd_rd_q, cmd_rd_d;
    logic [COORD_W-1:0] x_cnt_q, x_cnt_d;
    logic [COORD_W-1:0] y_cnt_q, y_cnt_d;
    logic [COORD_W-1:0] x_end_q, x_end_d;
    logic [COORD_W-1:0] y_end_q, y_end_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;

    logic [COORD_W-1:0] clip_x0;
    logic [COORD_W-1:0] clip_y0;
    logic [COORD_W-1:0] clip_x_end;
    logic [COORD_W-1:0] clip_y_end;
    logic               clip_empty;

    logic               xfer;
    logic               last_col;
    logic               last_row;

    // cmd_q only changes in IDLE, so the clip outputs stay valid for the whole run
    fill_rect_clip #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clip (
        .cmd_i   (cmd_q),
        .x0_o    (clip_x0),
        .y0_o    (clip_y0),
        .x_end_o (clip_x_end),
        .y_end_o (clip_y_end),
        .empty_o (clip_empty)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        color_d    = color_q;
        cmd_rd_d   = 1'b0;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;

        xfer     = (state_q == ST_RUN) && pix_ready;
        last_col = (x_cnt_q == x_end_q - COORD_W'(1));
        last_row = (y_cnt_q == y_end_q - COORD_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_rd_d    = 1'b1;
                    cmd_d.x     = cmd_data[X_LSB +: FIELD_W];
                    cmd_d.y     = cmd_data[Y_LSB +: FIELD_W];
                    cmd_d.wid   = cmd_data[WID_LSB +: FIELD_W];
                    cmd_d.hgt   = cmd_data[HGT_LSB +: FIELD_W];
                    color_d     = pack_color(cmd_data[R_LSB +: CHAN_W],
                                             cmd_data[G_LSB +: CHAN_W],
                                             cmd_data[B_LSB +: CHAN_W]);
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                x_end_d    = clip_x_end;
                y_end_d    = clip_y_end;
                x_cnt_d    = clip_x0;
                y_cnt_d    = clip_y0;
                row_base_d = ADDR_W'(clip_y0) * ADDR_W'(H_RES);
                state_d    = clip_empty ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (xfer) begin
                    if (!last_col) begin
                        x_cnt_d = x_cnt_q + COORD_W'(1);
                    end else if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        x_cnt_d    = clip_x0;
                        y_cnt_d    = y_cnt_q + COORD_W'(1);
                        row_base_d = row_base_q + ADDR_W'(H_RES);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            color_q    <= '0;
            cmd_rd_q   <= 1'b0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            color_q    <= color_d;
            cmd_rd_q   <= cmd_rd_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
        end
    end

    assign cmd_rd   = cmd_rd_q;
    assign pix_we   = (state_q == ST_RUN);
    assign pix_addr = row_base_q + ADDR_W'(x_cnt_q);
    assign pix_data = color_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_fill_rect_engine.sv
// Scoreboard bench for fill_rect_engine: a command FIFO model feeds the DUT, expected
// pixel writes are derived from the rectangle rules and checked by an independent monitor.
module tb_fill_rect_engine;

    localparam int HR    = 640;
    localparam int VR    = 480;
    localparam int AW    = 19;
    localparam int NRAND = 24;

    logic          clk = 1'b0;
    logic          rst_;
    logic          cmd_valid;
    logic [87:0]   cmd_data;
    logic          cmd_rd;
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic [11:0]   pix_data;
    logic          pix_ready;
    logic          busy;
    logic          done;

    fill_rect_engine #(
        .H_RES  (HR),
        .V_RES  (VR),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_rd    (cmd_rd),
        .pix_we    (pix_we),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int tag;
        int addr;
        int data;
    } pix_t;

    pix_t        exp_q[$];
    logic [87:0] fifo_q[$];

    int total = 0;
    int bad   = 0;
    int issued = 0;
    int aborted = 0;
    int ndone = 0;
    int exp_npix[64];
    bit timed[64];
    int load_cyc[64];
    bit rand_ready = 1'b0;
    bit stall_force = 1'b0;
    int stall_obs = 0;
    int cyc = 0;
    int inflight = -1;
    int pop_tag = 0;
    bit idle_chk = 1'b0;

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: every integer pixel of the clipped rectangle, row by row.
    task automatic issue(input int x, input int y, input int w, input int h,
                         input int r, input int g, input int b, input bit tm);
        int xi, yi, wi, hi, xe, ye, n, d;
        xi = x >> 3;
        yi = y >> 3;
        wi = w >> 3;
        hi = h >> 3;
        d  = ((r % 16) * 256) + ((g % 16) * 16) + (b % 16);
        n  = 0;
        if (wi > 0 && hi > 0 && xi < HR && yi < VR) begin
            xe = (xi + wi < HR) ? xi + wi : HR;
            ye = (yi + hi < VR) ? yi + hi : VR;
            for (int yy = yi; yy < ye; yy++) begin
                for (int xx = xi; xx < xe; xx++) begin
                    exp_q.push_back('{issued, yy * HR + xx, d});
                    n++;
                end
            end
        end
        exp_npix[issued] = n;
        timed[issued]    = tm;
        issued++;
        fifo_q.push_back({16'(x), 16'(y), 16'(w), 16'(h), 8'(r), 8'(g), 8'(b)});
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || ndone != issued - aborted || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL wait_all: timed out, done seen %0d wanted %0d", ndone,
                     issued - aborted);
        end
    endtask

    task automatic wait_load(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_rd && n < budget);
        total++;
        if (!cmd_rd) begin
            bad++;
            $display("FAIL wait_load: cmd_rd not seen, got 0 expected 1");
        end
    endtask

    // FIFO model: head visible while non-empty, popped after a sampled cmd_rd strobe
    initial begin
        bit rd_seen;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        forever begin
            @(negedge clk);
            rd_seen = cmd_rd && rst_;
            @(posedge clk);
            #1;
            if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
            cmd_valid = (fifo_q.size() > 0);
            cmd_data  = cmd_valid ? fifo_q[0] : '0;
        end
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_force)     pix_ready = 1'b0;
            else if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
            else                 pix_ready = 1'b1;
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ === 1'b1) begin
                cyc++;
                if (idle_chk) begin
                    check("busy_after_done", busy, 0);
                    check("done_width", done, 0);
                    idle_chk = 1'b0;
                end
                if (cmd_rd) begin
                    inflight = pop_tag;
                    pop_tag++;
                    if (inflight < 64) load_cyc[inflight] = cyc;
                end
                if (pix_we) begin
                    if (exp_q.size() == 0 || exp_q[0].tag != inflight) begin
                        total++;
                        bad++;
                        $display("FAIL pix_we: got write addr %0d expected no write", pix_addr);
                    end else begin
                        check("pix_addr", pix_addr, exp_q[0].addr);
                        check("pix_data", pix_data, exp_q[0].data);
                        if (pix_ready) void'(exp_q.pop_front());
                        else           stall_obs++;
                    end
                end
                if (done) begin
                    ndone++;
                    check("writes_left_at_done",
                          (exp_q.size() > 0 && exp_q[0].tag == inflight), 0);
                    if (inflight >= 0 && inflight < 64 && timed[inflight])
                        check("done_latency", cyc - load_cyc[inflight], exp_npix[inflight] + 1);
                    idle_chk = 1'b1;
                end
            end
        end
    end

    initial begin
        rst_ = 1'b0;
        repeat (3) @(posedge clk);
        #1 issue(0, 0, 'h200, 'h200, 'h0F, 0, 0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_rd", cmd_rd, 0);
        check("rst_pix_we", pix_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_pix_data", pix_data, 0);
        @(posedge clk);
        #2 rst_ = 1'b1;
        wait_all(6000);

        issue('h100, 'h100, 'h400, 'h400, 0, 'h0F, 0, 1'b1);
        wait_all(20000);

        issue('h1300, 0, 'h200, 'h0008, 'h3A, 'h5C, 'h7E, 1'b1);
        wait_all(500);

        issue('h40, 'h40, 0, 'h80, 'h11, 'h22, 'h33, 1'b1);
        issue('h50, 'h58, 'h40, 'h20, 'h44, 'h55, 'h66, 1'b1);
        wait_all(500);

        // Hold pix_ready low for 5 cycles while the third pixel is presented
        stall_obs = 0;
        issue(0, 0, 'h200, 'h200, 'h0F, 0, 0, 1'b0);
        wait_load(100);
        repeat (2) @(negedge clk);
        stall_force = 1'b1;
        repeat (5) @(negedge clk);
        stall_force = 1'b0;
        wait_all(6000);
        check("stall_cycles", stall_obs, 5);

        rand_ready = 1'b1;
        for (int i = 0; i < NRAND; i++) begin
            int rx;
            rx = (i % 4 == 0) ? $urandom_range(590 * 8, 650 * 8) : $urandom_range(0, 700 * 8);
            issue(rx, $urandom_range(0, 500 * 8), $urandom_range(0, 40 * 8),
                  $urandom_range(0, 6 * 8), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), 1'b0);
        end
        wait_all(40000);
        rand_ready = 1'b0;

        // Abandon a command mid-run with a short asynchronous reset pulse
        issue('h80, 'h80, 'h80, 'h80, 'h99, 'hAA, 'hBB, 1'b0);
        issue('h10, 'h20, 'h30, 'h18, 'hCC, 'hDD, 'hEE, 1'b1);
        wait_load(100);
        repeat (20) @(posedge clk);
        #1 rst_ = 1'b0;
        aborted++;
        while (exp_q.size() > 0 && exp_q[0].tag == issued - 2) void'(exp_q.pop_front());
        #1;
        check("midrst_pix_we", pix_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_cmd_rd", cmd_rd, 0);
        #2 rst_ = 1'b1;
        wait_all(500);

        check("exp_queue_empty", exp_q.size(), 0);
        check("done_count", ndone, issued - aborted);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fill_rect_engine.md
FILL_RECT_ENGINE -- requirements
Module: fill_rect_engine

Interface
REQ-001 Parameter H_RES, 640, frame width in pixels.
REQ-002 Parameter V_RES, 480, frame height in pixels.
REQ-003 Parameter ADDR_W, 19, pixel address width.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst_  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command FIFO non-empty.
REQ-007 cmd_data  in  88  FIFO head: [87:72] X, [71:56] Y, [55:40] WID, [39:24] HGT, [23:16] R, [15:8] G, [7:0] B.
REQ-008 cmd_rd  out  1  one-cycle FIFO pop strobe.
REQ-009 pix_we  out  1  pixel write valid.
REQ-010 pix_addr  out  ADDR_W  linear address, y*H_RES + x.
REQ-011 pix_data  out  12  {R[3:0], G[3:0], B[3:0]}.
REQ-012 pix_ready  in  1  frame-buffer accept; a write transfers when pix_we and pix_ready are both high at a clock edge.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse after the last pixel of a command.

Function
REQ-015 X, Y, WID and HGT shall be 13.3 fixed point; integer value = field >> 3, fraction truncated.
REQ-016 FSM states shall be IDLE, LOAD, RUN, DONE.
REQ-017 In IDLE with cmd_valid=1, cmd_rd shall pulse for 1 cycle, cmd_data shall be captured on that edge, and the next state shall be LOAD.
REQ-018 LOAD (1 cycle) shall compute x_end = min(x0+w, H_RES), y_end = min(y0+h, V_RES), using 14-bit sums with no wrap.
REQ-019 LOAD shall also compute row_base = y0*H_RES.
REQ-020 If w=0, h=0, x0>=H_RES or y0>=V_RES, LOAD shall go directly to DONE with zero writes.
REQ-021 In RUN, pix_we shall be 1 and pix_addr = row_base + x_cnt, scanning left to right, then top to bottom.
REQ-022 Counters shall advance only on a transfer; while pix_ready=0, pix_addr and pix_data shall hold stable.
REQ-023 At x_cnt = x_end-1 a transfer shall reset x_cnt to x0, increment y_cnt and add H_RES to row_base.
REQ-024 The transfer at (x_end-1, y_end-1) shall move the FSM to DONE; pix_we shall be 0 in the following cycle.
REQ-025 DONE shall assert done for 1 cycle and return to IDLE.
REQ-026 A new command shall not be popped before IDLE, so the minimum gap is 1 idle cycle between commands.
REQ-027 Throughput shall be 1 pixel/cycle with pix_ready held high.
REQ-028 cmd_valid changes outside IDLE shall be ignored.

Reset
REQ-029 On rst_=0 the FSM shall enter IDLE immediately, regardless of clock.
REQ-030 On rst_=0, cmd_rd, pix_we, busy and done shall be 0, and pix_addr, pix_data and all counters shall be 0.
REQ-031 Reset mid-RUN shall abandon the current command with no further writes; the FIFO entry already popped is lost.

Structure
REQ-032 Shared package gfx_pkg shall hold H_RES, V_RES, FRAC_BITS=3, COLOR_W=4, the cmd_data field offsets and the FSM state encoding.
REQ-033 A combinational sub-module fill_rect_clip shall compute x0, y0, x_end, y_end and the empty flag from the captured command.

Verification
REQ-034 X=0,Y=0,WID=0x0200,HGT=0x0200,R=0x0F,G=0,B=0, pix_ready=1 -> 4096 writes, first addr 0, last addr 40383, data 0xF00, done 4097 cycles after LOAD.
REQ-035 X=Y=0x0100, WID=HGT=0x0400, G=0x0F -> 16384 writes, first addr 20512, row 2 starts at 21152, data 0x0F0.
REQ-036 X=0x1300 (608), WID=0x0200, Y=0, HGT=0x0008 -> 32 writes, addrs 608..639, no addr >= 640.
REQ-037 pix_ready low for 5 cycles during the third write of the REQ-034 command -> addr 2 held 5 cycles, no skip or duplicate, total count still 4096.
REQ-038 WID=0 command followed by a valid command -> done pulse with zero writes, then the second command executes normally.
REQ-039 rst_ low for 3 ns mid-RUN -> pix_we=0 and busy=0 asynchronously; after release the next FIFO command starts from IDLE.
